afe_spi_listener: RTL and testbench
===================================

// Module: afe_spi_listener
// PURPOSE
//  Receiving end of the AFE attenuator SPI link (AFE_SPI_CLK/SDI/LE). It oversamples the three
//  SPI lines in the clk domain and shifts SDI into a register MSB first. On the rising edge of
//  LE it validates the frame length and presents the latched word.
//  - Used as the synthesizable AFE model in loopback benches.
//  - Used as the on-chip monitor that reads back what the SPI master actually sent.
// PARAMETERS
//  WIDTH        16   attenuator word length in bits (2..32)
//  SYNC_STAGES  2    synchronizer flops per SPI input (>=2)
//  CNT_WIDTH    8    width of bitCount and frameCount
// PORTS
//  clk            in   1          system clock; every register is clocked by this clock
//  reset          in   1          asynchronous, active-high reset
//  spiClk         in   1          SPI clock, asynchronous to clk; data is sampled on its rising edge
//  spiSdi         in   1          SPI serial data, asynchronous to clk
//  spiLe          in   1          latch enable, asynchronous to clk; high = idle/latch, low = shifting
//  clearErrors    in   1          one-cycle pulse that clears the sticky error flags
//  latchedValue   out  WIDTH      last accepted word
//  latchedStrobe  out  1          one-cycle pulse when latchedValue updates
//  bitCount       out  CNT_WIDTH  rising spiClk edges counted in the current frame; saturates at all-ones
//  frameCount     out  CNT_WIDTH  number of frames latched; wraps at all-ones -> 0
//  shortError     out  1          sticky: LE rose with 0 < bitCount < WIDTH
//  overrunError   out  1          sticky: LE rose with bitCount > WIDTH
// BEHAVIOUR
//  Reset values
//   - All outputs are 0.
//   - Shift register is 0.
//   - Synchronizer flops are 0, except the spiLe chain, which resets to 1 (idle).
//   - Reset asserted mid-frame discards the partial frame.
//   - After reset, the first LE rise requires LE to be seen low first.
//  Input sampling
//   - Each input passes through SYNC_STAGES flops, followed by one history flop for edge detection.
//   - sclkRise = synced spiClk & ~prev.
//   - leRise = synced spiLe & ~prev.
//   - leFall = ~synced spiLe & prev.
//   - Each spiClk and spiLe level must be held for at least 2 clk periods. Faster input is
//     outside the supported range and has no defined behaviour.
//  Shifting
//   - On sclkRise with synced LE low: shreg <= {shreg[WIDTH-2:0], syncedSdi}.
//   - On the same event, bitCount increments, saturating at all-ones.
//   - sclkRise while synced LE is high is ignored: no shift, no count.
//  Frame end (leRise)
//   - Latch decisions use the bitCount value before any same-cycle edge. A sclkRise in the same
//     cycle as leRise is dropped.
//   - bitCount == 0: no latch, no error. This is an idle LE toggle.
//   - bitCount == WIDTH:
//       latchedValue <= shreg
//       latchedStrobe = 1 for one cycle
//       frameCount++
//   - bitCount > WIDTH (including saturated): latch the last WIDTH bits (shreg) as a real shift
//     chain would. Strobe and frameCount behave as for a good frame. overrunError <= 1.
//   - 0 < bitCount < WIDTH: latchedValue is unchanged, no strobe, shortError <= 1.
//   - bitCount <= 0 and shreg <= 0 on the cycle after leRise.
//   - leFall also clears bitCount. This covers a master that pulses LE without clocking.
//  Errors
//   - clearErrors clears both error flags.
//   - If clearErrors and a new error event occur in the same cycle, the set wins.
//  Latency
//   - From the spiLe pin rising to latchedStrobe high: SYNC_STAGES+1 clk cycles.
//   - latchedValue is valid in the same cycle as the strobe.
// TESTING
//  - WIDTH=16; send 0xA5C3 MSB first with LE low, then raise LE -> latchedValue=0xA5C3,
//    exactly one strobe, frameCount=1, no error flags.
//  - Send 10 bits 0x3FF, then LE rise -> latchedValue keeps its previous value, no strobe,
//    shortError=1; clearErrors pulse -> shortError=0.
//  - Send 20 bits 0xF_1234, then LE rise -> latchedValue=0x1234, strobe, overrunError=1,
//    frameCount increments.
//  - Assert reset after 8 of 16 bits, release, then send a full 0x0001 frame ->
//    latchedValue=0x0001, bitCount=0 after the latch, no error flags.
//  - Preload frameCount=255 with 255 good frames, send 1 more -> frameCount=0.
//    Toggle LE with no clocks -> no strobe, no error.
//  - Pulse clearErrors in the same cycle as a short-frame leRise -> shortError=1.
//    Toggle spiClk with LE high -> bitCount stays 0.

Source files
------------

// File: rtl/afe_spi_listener.sv
// Receive side of the AFE attenuator SPI link: synchronizes CLK/SDI/LE into clk,
// shifts SDI MSB first and latches the word on LE rise after checking frame length.
module afe_spi_listener #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spiClk,
    input  logic                 spiSdi,
    input  logic                 spiLe,
    input  logic                 clearErrors,
    output logic [WIDTH-1:0]     latchedValue,
    output logic                 latchedStrobe,
    output logic [CNT_WIDTH-1:0] bitCount,
    output logic [CNT_WIDTH-1:0] frameCount,
    output logic                 shortError,
    output logic                 overrunError
);

    localparam logic [CNT_WIDTH-1:0] WIDTH_C = CNT_WIDTH'(WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] le_sync_q, le_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   le_prev_q, le_prev_d;
    logic [WIDTH-1:0]       shreg_q, shreg_d;
    logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [WIDTH-1:0]       latched_q, latched_d;
    logic                   strobe_q, strobe_d;
    logic                   short_q, short_d;
    logic                   overrun_q, overrun_d;

    logic sclk_s, sdi_s, le_s;
    logic sclk_rise, le_rise, le_fall;
    logic short_set, overrun_set;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spiClk};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spiSdi};
        le_sync_d   = {le_sync_q[SYNC_STAGES-2:0], spiLe};

        sclk_s = sclk_sync_q[SYNC_STAGES-1];
        sdi_s  = sdi_sync_q[SYNC_STAGES-1];
        le_s   = le_sync_q[SYNC_STAGES-1];

        sclk_prev_d = sclk_s;
        le_prev_d   = le_s;

        sclk_rise = sclk_s & ~sclk_prev_q;
        le_rise   = le_s & ~le_prev_q;
        le_fall   = ~le_s & le_prev_q;

        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        latched_d   = latched_q;
        strobe_d    = 1'b0;
        short_set   = 1'b0;
        overrun_set = 1'b0;

        // Frame end decides on the pre-edge count; an SCLK edge in that cycle is dropped.
        if (le_rise) begin
            if (bit_cnt_q >= WIDTH_C) begin
                latched_d   = shreg_q;
                strobe_d    = 1'b1;
                frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                overrun_set = (bit_cnt_q != WIDTH_C);
            end else if (bit_cnt_q != '0) begin
                short_set = 1'b1;
            end
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else if (le_fall) begin
            bit_cnt_d = '0;
        end else if (sclk_rise && !le_s) begin
            shreg_d = {shreg_q[WIDTH-2:0], sdi_s};
            if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
        end

        // A new error wins over a simultaneous clear.
        short_d   = short_set | (short_q & ~clearErrors);
        overrun_d = overrun_set | (overrun_q & ~clearErrors);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            sdi_sync_q  <= '0;
            le_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            le_prev_q   <= 1'b1;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            latched_q   <= '0;
            strobe_q    <= 1'b0;
            short_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            le_sync_q   <= le_sync_d;
            sclk_prev_q <= sclk_prev_d;
            le_prev_q   <= le_prev_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            latched_q   <= latched_d;
            strobe_q    <= strobe_d;
            short_q     <= short_d;
            overrun_q   <= overrun_d;
        end
    end

    assign latchedValue  = latched_q;
    assign latchedStrobe = strobe_q;
    assign bitCount      = bit_cnt_q;
    assign frameCount    = frame_cnt_q;
    assign shortError    = short_q;
    assign overrunError  = overrun_q;

endmodule

// File: tb/tb_afe_spi_listener.sv
// Randomized bench for afe_spi_listener; expectations come from a bit-queue frame model.
module tb_afe_spi_listener;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        spiClk, spiSdi, spiLe, clearErrors;
    logic [W-1:0] latchedValue;
    logic        latchedStrobe;
    logic [7:0]  bitCount, frameCount;
    logic        shortError, overrunError;

    afe_spi_listener #(.WIDTH(W), .SYNC_STAGES(2), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .spiClk(spiClk), .spiSdi(spiSdi), .spiLe(spiLe),
        .clearErrors(clearErrors), .latchedValue(latchedValue), .latchedStrobe(latchedStrobe),
        .bitCount(bitCount), .frameCount(frameCount), .shortError(shortError),
        .overrunError(overrunError)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    // reference model state
    logic        bits[$];
    logic [W-1:0] exp_val = '0;
    int          exp_frames = 0;
    int          exp_strobes = 0;
    logic        exp_short = 1'b0;
    logic        exp_ovr = 1'b0;

    always @(negedge clk) if (latchedStrobe === 1'b1) strobe_cnt++;

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int n, input logic [63:0] val);
        logic b;
        bits.delete();
        for (int i = 0; i < n; i++) begin
            b = (n - 1 - i < 64) ? val[n-1-i] : 1'($urandom_range(0, 1));
            bits.push_back(b);
            spiSdi = b;
            cyc(2);
            spiClk = 1'b1;
            cyc(2);
            spiClk = 1'b0;
        end
        cyc(3);
    endtask

    task automatic model_clear();
        exp_short = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic pulse_clear();
        clearErrors = 1'b1;
        cyc(1);
        clearErrors = 1'b0;
        model_clear();
    endtask

    task automatic run_frame(input int n, input logic [63:0] val);
        int n_sent;
        int exp_bc;
        logic will_latch;
        logic [W-1:0] v;
        spiLe = 1'b0;
        cyc(3);
        send_bits(n, val);
        n_sent = bits.size();
        exp_bc = (n_sent > 255) ? 255 : n_sent;
        checks++;
        if (bitCount !== 8'(exp_bc)) begin
            errors++;
            $display("FAIL bitcount_pre n=%0d got %0d want %0d", n, bitCount, exp_bc);
        end
        will_latch = (n_sent >= W);
        if (will_latch) begin
            for (int i = 0; i < W; i++) v[i] = bits[n_sent-1-i];
            exp_val     = v;
            exp_frames  = (exp_frames + 1) % 256;
            exp_strobes = exp_strobes + 1;
            if (n_sent > W) exp_ovr = 1'b1;
        end else if (n_sent > 0) begin
            exp_short = 1'b1;
        end
        spiLe = 1'b1;
        cyc(2);
        checks++;
        if (latchedStrobe !== 1'b0) begin
            errors++;
            $display("FAIL strobe_early n=%0d got %b want 0", n, latchedStrobe);
        end
        cyc(1);
        checks++;
        if (latchedStrobe !== will_latch || latchedValue !== exp_val) begin
            errors++;
            $display("FAIL latch_latency n=%0d strobe %b want %b value %h want %h",
                     n, latchedStrobe, will_latch, latchedValue, exp_val);
        end
        cyc(3);
        checks++;
        if (latchedValue !== exp_val || frameCount !== 8'(exp_frames) || bitCount !== 8'd0) begin
            errors++;
            $display("FAIL frame_result n=%0d value %h want %h frames %0d want %0d bitcount %0d want 0",
                     n, latchedValue, exp_val, frameCount, exp_frames, bitCount);
        end
        checks++;
        if (strobe_cnt !== exp_strobes || shortError !== exp_short || overrunError !== exp_ovr) begin
            errors++;
            $display("FAIL frame_flags n=%0d strobes %0d want %0d short %b want %b ovr %b want %b",
                     n, strobe_cnt, exp_strobes, shortError, exp_short, overrunError, exp_ovr);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        spiClk = 1'b0; spiSdi = 1'b0; spiLe = 1'b1; clearErrors = 1'b0;
        cyc(2);
        reset = 1'b0;
        exp_val = '0; exp_frames = 0;
        model_clear();
        bits.delete();
        cyc(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spiClk = 1'b0; spiSdi = 1'b0; spiLe = 1'b1; clearErrors = 1'b0;
        cyc(3);
        checks++;
        if (latchedValue !== '0 || latchedStrobe !== 1'b0 || bitCount !== 8'd0 ||
            frameCount !== 8'd0 || shortError !== 1'b0 || overrunError !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got val %h stb %b bc %0d fc %0d sh %b ov %b want all 0",
                     latchedValue, latchedStrobe, bitCount, frameCount, shortError, overrunError);
        end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_good_frame();
        run_frame(16, 64'hA5C3);
    endtask

    task automatic test_short_frame();
        run_frame(10, 64'h3FF);
        pulse_clear();
        cyc(1);
        checks++;
        if (shortError !== 1'b0) begin
            errors++;
            $display("FAIL short_clear got %b want 0", shortError);
        end
    endtask

    task automatic test_overrun();
        run_frame(20, 64'hF1234);
        pulse_clear();
        cyc(1);
        checks++;
        if (overrunError !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear got %b want 0", overrunError);
        end
    endtask

    task automatic test_saturate();
        run_frame(260, {$urandom, $urandom});
        pulse_clear();
    endtask

    task automatic test_idle_clocks();
        for (int i = 0; i < 3; i++) begin
            spiClk = 1'b1; cyc(2);
            spiClk = 1'b0; cyc(2);
        end
        cyc(2);
        checks++;
        if (bitCount !== 8'd0) begin
            errors++;
            $display("FAIL idle_clocks bitcount got %0d want 0", bitCount);
        end
        run_frame(0, 64'h0);
    endtask

    task automatic test_clear_collision();
        spiLe = 1'b0;
        cyc(3);
        send_bits(5, 64'h15);
        spiLe = 1'b1;
        cyc(2);
        clearErrors = 1'b1;
        cyc(1);
        clearErrors = 1'b0;
        cyc(1);
        exp_short = 1'b1;
        checks++;
        if (shortError !== 1'b1 || strobe_cnt !== exp_strobes) begin
            errors++;
            $display("FAIL clear_collision short %b want 1 strobes %0d want %0d",
                     shortError, strobe_cnt, exp_strobes);
        end
        pulse_clear();
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            run_frame($urandom_range(0, 24), {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) pulse_clear();
        end
        pulse_clear();
    endtask

    task automatic test_reset_mid_frame();
        spiLe = 1'b0;
        cyc(3);
        send_bits(8, 64'hA5);
        do_reset();
        checks++;
        if (bitCount !== 8'd0 || latchedValue !== '0 || frameCount !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid bc %0d val %h fc %0d want 0", bitCount, latchedValue, frameCount);
        end
        run_frame(16, 64'h0001);
    endtask

    task automatic test_frame_wrap();
        do_reset();
        for (int f = 0; f < 255; f++) run_frame(16, 64'($urandom));
        checks++;
        if (frameCount !== 8'd255) begin
            errors++;
            $display("FAIL wrap_preload got %0d want 255", frameCount);
        end
        run_frame(16, 64'h5A5A);
        checks++;
        if (frameCount !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero got %0d want 0", frameCount);
        end
        run_frame(0, 64'h0);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_overrun();
        test_saturate();
        test_idle_clocks();
        test_clear_collision();
        test_random();
        test_reset_mid_frame();
        test_frame_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
